// File: rtl/async_fifo_rd_ctrl.sv
// Read-side control for the asynchronous FIFO: write-pointer synchroniser, read pointers, empty/valid/underflow.
// Optional occupancy outputs (rd_level, almost_empty) are enabled by defining FIFO_RD_LEVEL_EN.
module async_fifo_rd_ctrl #(
    parameter int ADDR_W      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AE_THRESH   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [ADDR_W:0]   wptr_gray,
    output logic [ADDR_W:0]   rptr_gray,
    output logic [ADDR_W-1:0] raddr,
    output logic              empty,
    output logic              rd_valid,
    output logic              rd_underflow,
    output logic [ADDR_W:0]   rd_level,
    output logic              almost_empty
);
    localparam int PW = ADDR_W + 1;

    if (SYNC_STAGES < 2 || AE_THRESH < 0) begin : g_bad_param
        $error("async_fifo_rd_ctrl: SYNC_STAGES must be >= 2 and AE_THRESH >= 0");
    end

    logic [PW-1:0] sync_reg [SYNC_STAGES];
    logic [PW-1:0] wq_sync;
    logic [PW-1:0] rptr_bin_reg;
    logic [PW-1:0] rptr_bin_next;
    logic [PW-1:0] rptr_gray_reg;
    logic [PW-1:0] rptr_gray_next;
    logic          empty_reg;
    logic          rd_valid_reg;
    logic          rd_underflow_reg;
    logic          pop;

    // Plain flop chain: no logic between stages so each bit resolves independently.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= '0;
            end
        end else begin
            sync_reg[0] <= wptr_gray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= sync_reg[i-1];
            end
        end
    end

    assign wq_sync = sync_reg[SYNC_STAGES-1];

    always_comb begin
        pop            = rd_en & ~empty_reg;
        rptr_bin_next  = pop ? rptr_bin_reg + 1'b1 : rptr_bin_reg;
        rptr_gray_next = rptr_bin_next ^ (rptr_bin_next >> 1);
    end

    // Empty is judged against the post-pop pointer so the last pop raises it on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rptr_bin_reg     <= '0;
            rptr_gray_reg    <= '0;
            empty_reg        <= 1'b1;
            rd_valid_reg     <= 1'b0;
            rd_underflow_reg <= 1'b0;
        end else begin
            rptr_bin_reg     <= rptr_bin_next;
            rptr_gray_reg    <= rptr_gray_next;
            empty_reg        <= (rptr_gray_next == wq_sync);
            rd_valid_reg     <= pop;
            rd_underflow_reg <= rd_en & empty_reg;
        end
    end

    assign rptr_gray    = rptr_gray_reg;
    assign raddr        = rptr_bin_reg[ADDR_W-1:0];
    assign empty        = empty_reg;
    assign rd_valid     = rd_valid_reg;
    assign rd_underflow = rd_underflow_reg;

`ifdef FIFO_RD_LEVEL_EN
    logic [PW-1:0] wbin_sync;
    logic [PW-1:0] level_next;
    logic [PW-1:0] rd_level_reg;
    logic          almost_empty_reg;

    // Gray->binary: each binary bit is the XOR of all Gray bits at or above it.
    for (genvar gi = 0; gi < PW; gi++) begin : g_g2b
        assign wbin_sync[gi] = ^(wq_sync >> gi);
    end

    assign level_next = wbin_sync - rptr_bin_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_level_reg     <= '0;
            almost_empty_reg <= 1'b1;
        end else begin
            rd_level_reg     <= level_next;
            almost_empty_reg <= (level_next <= PW'(AE_THRESH));
        end
    end

    assign rd_level     = rd_level_reg;
    assign almost_empty = almost_empty_reg;
`else
    assign rd_level     = '0;
    assign almost_empty = 1'b0;
`endif

endmodule

// File: doc/async_fifo_rd_ctrl.md
Name: async_fifo_rd_ctrl

Overview:
- Read-side control for the asynchronous FIFO; counterpart to the write-side logic clocked by the divided write clock.
- Runs entirely in the read clock domain.
- Synchronises the write pointer (Gray), maintains the binary/Gray read pointer, drives the RAM read address, and generates empty, read-valid and underflow indications.
- Sits between the dual-port FIFO RAM and the downstream consumer (e.g. UART TX).

Parameters:
- ADDR_W, 4, RAM address width; FIFO depth = 2**ADDR_W; pointers are ADDR_W+1 bits.
- SYNC_STAGES, 2, number of flops in the wptr_gray synchroniser; legal range >= 2.
- AE_THRESH, 2, almost-empty threshold in entries; used only with the optional feature.

Ports:
- clk  in  1  read-domain clock.
- rst  in  1  synchronous, active-high reset.
- rd_en  in  1  read request from consumer.
- wptr_gray  in  ADDR_W+1  write pointer (Gray) from the write domain; asynchronous to clk.
- rptr_gray  out  ADDR_W+1  registered read pointer (Gray) to the write domain.
- raddr  out  ADDR_W  RAM read address = rptr_bin[ADDR_W-1:0].
- empty  out  1  registered empty flag.
- rd_valid  out  1  1-cycle pulse; RAM data at the previous raddr is valid this cycle.
- rd_underflow  out  1  1-cycle pulse; rd_en was asserted while empty.
- rd_level  out  ADDR_W+1  occupancy seen by the reader (optional feature).
- almost_empty  out  1  rd_level <= AE_THRESH (optional feature).

Behaviour:
- Reset (sampled on posedge clk while rst=1):
  - synchroniser flops = 0, rptr_bin = 0, rptr_gray = 0.
  - empty = 1, rd_valid = 0, rd_underflow = 0, rd_level = 0, almost_empty = 1 (feature on).
  - Reset mid-operation discards all pointer state; nothing is preserved.
- Synchroniser: wptr_gray passes through SYNC_STAGES flops; the last stage is wq_sync. No logic between the flops.
- Pop: pop = rd_en & ~empty.
  - On pop: rptr_bin_next = rptr_bin + 1, modulo 2**(ADDR_W+1); wrap from all-ones to 0 is natural.
  - rptr_gray_next = rptr_bin_next ^ (rptr_bin_next >> 1). Both pointers registered together.
- raddr is combinational from registered rptr_bin. The RAM read is synchronous: data appears 1 cycle after the pop edge.
- rd_valid <= pop (registered), so it coincides with the RAM output for the popped entry.
- empty <= (rptr_gray_next == wq_sync), evaluated every cycle.
  - A pop of the last entry asserts empty on the same edge that advances the pointer.
  - Back-to-back pops never read past the last entry.
- Empty-deassert latency: if wptr_gray changes and is first captured at edge k, empty falls at edge k+SYNC_STAGES. Pointer equality only, no "full" interpretation on the read side.
- rd_underflow <= rd_en & empty (registered). The pointer does not move; no rd_valid.
- Simultaneous write arrival and last-entry pop:
  - empty is computed from the post-pop pointer against the current wq_sync.
  - A new write seen later deasserts empty per the latency rule above.
- rd_en held high continuously: one pop per cycle while non-empty. Throughput is 1 entry/clk.

Optional Feature:
- Macro: FIFO_RD_LEVEL_EN.
- Defined:
  - wq_sync is converted Gray->binary (wbin_sync).
  - rd_level <= wbin_sync - rptr_bin_next (mod 2**(ADDR_W+1)), registered, same edge as empty.
  - almost_empty <= (that value <= AE_THRESH).
  - rd_level range is 0..2**ADDR_W.
- Undefined: no Gray->binary logic; rd_level tied 0, almost_empty tied 0. Port list is unchanged in both builds.

Test Plan:
- Reset: assert rst 2 cycles with wptr_gray=5'b00011 -> empty=1, rptr_gray=0, raddr=0, rd_valid=0, rd_underflow=0 after release.
- Latency: wptr_gray 0->1 (one write), SYNC_STAGES=2, captured at edge k -> empty=0 at edge k+2. rd_en 1 cycle -> raddr 0->1, rd_valid=1 next cycle, empty=1 on the pop edge.
- Underflow: rd_en=1 while empty=1 for 3 cycles -> rd_underflow high 3 cycles, rptr_gray stays 0, rd_valid stays 0.
- Burst/wrap: drive wptr_gray to Gray(16) (full, 5'b11000), hold rd_en 16 cycles -> raddr 0..15 then 0, rptr_bin 16 (gray 5'b11000), 16 rd_valid pulses, empty=1 after the 16th pop. Second lap to rptr_bin 31->0 wraps cleanly.
- Full-speed: 8 entries present, rd_en continuous -> exactly 8 consecutive rd_valid pulses, no gap, no 9th.
- FIFO_RD_LEVEL_EN: wptr=Gray(5), no pops -> rd_level=5, almost_empty=0. Pop 3 -> rd_level 4,3,2, almost_empty=1 at level 2. Without macro both read 0 throughout.
